// File: rtl/dcache_refill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcache_refill_ctrl : data-cache miss handler (victim write-back + refill)   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dcache_refill_ctrl #(
  parameter int ADDRESS_SIZE = 32,
  parameter int WORD_SIZE    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         miss_valid_i,
  input  logic                         miss_is_write_i,
  input  logic [ADDRESS_SIZE-1:0]      miss_addr_i,
  input  logic                         victim_dirty_i,
  input  logic [ADDRESS_SIZE-16:0]     victim_tag_i,
  input  logic [8*WORD_SIZE-1:0]       victim_line_i,
  output logic                         miss_busy_o,
  output logic                         fill_valid_o,
  output logic [9:0]                   fill_index_o,
  output logic [ADDRESS_SIZE-16:0]     fill_tag_o,
  output logic [8*WORD_SIZE-1:0]       fill_line_o,
  output logic [1:0]                   fill_state_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADDRESS_SIZE-1:0]      mem_addr_o,
  output logic [WORD_SIZE-1:0]         mem_wdata_o,
  input  logic                         mem_ack_i,
  input  logic [WORD_SIZE-1:0]         mem_rdata_i
);

  localparam int TAG_W  = ADDRESS_SIZE - 15;
  localparam int LINE_W = 8 * WORD_SIZE;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WB   = 2'd1;
  localparam logic [1:0] c_RD   = 2'd2;
  localparam logic [1:0] c_FILL = 2'd3;

  localparam logic [1:0] c_SHARED   = 2'b01;
  localparam logic [1:0] c_MODIFIED = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [2:0]        beat_q;
  logic [TAG_W-1:0]  tag_q;
  logic [TAG_W-1:0]  vtag_q;
  logic [9:0]        index_q;
  logic [1:0]        fill_state_q;
  logic [LINE_W-1:0] vline_q;
  logic [LINE_W-1:0] line_q;

  logic w_accept;
  logic w_beat_done;
  logic w_last_beat;
  logic w_unused;

  assign w_accept    = (state_q == c_IDLE) && miss_valid_i;
  assign w_beat_done = mem_req_o && mem_ack_i;
  assign w_last_beat = w_beat_done && (beat_q == 3'd7);

  // Line offset never matters: beats always ascend from word 0.
  assign w_unused = ^miss_addr_i[4:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (miss_valid_i) begin
          state_d = victim_dirty_i ? c_WB : c_RD;
        end
      end
      c_WB: begin
        if (w_last_beat) begin
          state_d = c_RD;
        end
      end
      c_RD: begin
        if (w_last_beat) begin
          state_d = c_FILL;
        end
      end
      c_FILL: begin
        state_d = c_IDLE;
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  always_comb begin
    miss_busy_o  = 1'b0;
    fill_valid_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    case (state_q)
      c_WB: begin
        miss_busy_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {vtag_q, index_q, beat_q, 2'b00};
        mem_wdata_o = vline_q[int'(beat_q)*WORD_SIZE +: WORD_SIZE];
      end
      c_RD: begin
        miss_busy_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {tag_q, index_q, beat_q, 2'b00};
      end
      c_FILL: begin
        miss_busy_o  = 1'b1;
        fill_valid_o = 1'b1;
      end
      default: begin
        miss_busy_o = 1'b0;
      end
    endcase
  end

  // Victim data is captured once at acceptance so the cache may reuse the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q       <= 3'd0;
      tag_q        <= '0;
      vtag_q       <= '0;
      index_q      <= '0;
      fill_state_q <= 2'b00;
      vline_q      <= '0;
      line_q       <= '0;
    end else begin
      if (w_accept) begin
        beat_q       <= 3'd0;
        tag_q        <= miss_addr_i[ADDRESS_SIZE-1:15];
        index_q      <= miss_addr_i[14:5];
        vtag_q       <= victim_tag_i;
        vline_q      <= victim_line_i;
        fill_state_q <= miss_is_write_i ? c_MODIFIED : c_SHARED;
      end else if (w_beat_done) begin
        beat_q <= beat_q + 3'd1;
      end
      if ((state_q == c_RD) && w_beat_done) begin
        line_q[int'(beat_q)*WORD_SIZE +: WORD_SIZE] <= mem_rdata_i;
      end
    end
  end

  assign fill_index_o = index_q;
  assign fill_tag_o   = tag_q;
  assign fill_line_o  = line_q;
  assign fill_state_o = fill_state_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_refill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dcache_refill_ctrl : scoreboard bench for the data-cache refill control  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dcache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_valid_i;
    logic         miss_is_write_i;
    logic [31:0]  miss_addr_i;
    logic         victim_dirty_i;
    logic [16:0]  victim_tag_i;
    logic [255:0] victim_line_i;
    logic         miss_busy_o;
    logic         fill_valid_o;
    logic [9:0]   fill_index_o;
    logic [16:0]  fill_tag_o;
    logic [255:0] fill_line_o;
    logic [1:0]   fill_state_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic         mem_ack_i;
    logic [31:0]  mem_rdata_i;

    dcache_refill_ctrl #(.ADDRESS_SIZE(32), .WORD_SIZE(32)) dut (
        .clk(clk), .rst(rst),
        .miss_valid_i(miss_valid_i), .miss_is_write_i(miss_is_write_i), .miss_addr_i(miss_addr_i),
        .victim_dirty_i(victim_dirty_i), .victim_tag_i(victim_tag_i), .victim_line_i(victim_line_i),
        .miss_busy_o(miss_busy_o), .fill_valid_o(fill_valid_o), .fill_index_o(fill_index_o),
        .fill_tag_o(fill_tag_o), .fill_line_o(fill_line_o), .fill_state_o(fill_state_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [9:0]   index;
        logic [16:0]  tag;
        logic [1:0]   state;
        logic [255:0] line;
    } fill_t;

    beat_t exp_beats[$];
    fill_t exp_fills[$];

    int n_cmp = 0;
    int n_fail = 0;
    int fills_seen = 0;
    int fills_exp = 0;
    int spurious = 0;
    int rd_acks = 0;
    int stall_left = 0;
    bit stall_en = 1'b0;
    bit held = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;

    task automatic push_miss(input logic [31:0] a, input logic w, input logic d,
                             input logic [16:0] vt, input logic [255:0] vl);
        beat_t b;
        fill_t f;
        logic [2:0] bb;
        f.line = '0;
        if (d) begin
            for (int k = 0; k < 8; k++) begin
                bb = 3'(k);
                b.we = 1'b1;
                b.addr = {vt, a[14:5], bb, 2'b00};
                b.wdata = vl[32*k +: 32];
                exp_beats.push_back(b);
            end
        end
        for (int k = 0; k < 8; k++) begin
            bb = 3'(k);
            b.we = 1'b0;
            b.addr = {a[31:15], a[14:5], bb, 2'b00};
            b.wdata = '0;
            exp_beats.push_back(b);
            f.line[32*k +: 32] = b.addr;
        end
        f.index = a[14:5];
        f.tag = a[31:15];
        f.state = w ? 2'b11 : 2'b01;
        exp_fills.push_back(f);
        fills_exp++;
    endtask

    task automatic cycle(input bit allow);
        beat_t e;
        fill_t f;
        @(negedge clk);
        if (mem_req_o) begin
            if (held) begin
                n_cmp++;
                if (mem_addr_o !== prev_addr) begin
                    n_fail++;
                    $error("FAIL hold_addr: observed %0h expected %0h", mem_addr_o, prev_addr);
                end
                n_cmp++;
                if (mem_we_o !== prev_we) begin
                    n_fail++;
                    $error("FAIL hold_we: observed %0h expected %0h", mem_we_o, prev_we);
                end
                n_cmp++;
                if (mem_wdata_o !== prev_wdata) begin
                    n_fail++;
                    $error("FAIL hold_wdata: observed %0h expected %0h", mem_wdata_o, prev_wdata);
                end
            end else begin
                stall_left = stall_en ? int'($urandom_range(0, 5)) : 0;
            end
            if (allow && stall_left == 0) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = mem_addr_o;
                held = 1'b0;
                if (!mem_we_o) rd_acks++;
                if (exp_beats.size() == 0) begin
                    spurious++;
                end else begin
                    e = exp_beats.pop_front();
                    n_cmp++;
                    if (mem_we_o !== e.we) begin
                        n_fail++;
                        $error("FAIL beat_we: observed %0h expected %0h", mem_we_o, e.we);
                    end
                    n_cmp++;
                    if (mem_addr_o !== e.addr) begin
                        n_fail++;
                        $error("FAIL beat_addr: observed %0h expected %0h", mem_addr_o, e.addr);
                    end
                    if (e.we) begin
                        n_cmp++;
                        if (mem_wdata_o !== e.wdata) begin
                            n_fail++;
                            $error("FAIL beat_wdata: observed %0h expected %0h", mem_wdata_o, e.wdata);
                        end
                    end
                end
            end else begin
                mem_ack_i = 1'b0;
                mem_rdata_i = $urandom;
                if (stall_left > 0) stall_left--;
                held = 1'b1;
                prev_we = mem_we_o;
                prev_addr = mem_addr_o;
                prev_wdata = mem_wdata_o;
            end
        end else begin
            mem_ack_i = 1'($urandom);
            mem_rdata_i = $urandom;
            held = 1'b0;
        end
        if (fill_valid_o) begin
            fills_seen++;
            if (exp_fills.size() == 0) begin
                spurious++;
            end else begin
                f = exp_fills.pop_front();
                n_cmp++;
                if (fill_index_o !== f.index) begin
                    n_fail++;
                    $error("FAIL fill_index: observed %0h expected %0h", fill_index_o, f.index);
                end
                n_cmp++;
                if (fill_tag_o !== f.tag) begin
                    n_fail++;
                    $error("FAIL fill_tag: observed %0h expected %0h", fill_tag_o, f.tag);
                end
                n_cmp++;
                if (fill_state_o !== f.state) begin
                    n_fail++;
                    $error("FAIL fill_state: observed %0h expected %0h", fill_state_o, f.state);
                end
                n_cmp++;
                if (fill_line_o !== f.line) begin
                    n_fail++;
                    $error("FAIL fill_line: observed %0h expected %0h", fill_line_o, f.line);
                end
            end
        end
    endtask

    task automatic do_miss(input logic [31:0] a, input logic w, input logic d,
                           input logic [16:0] vt, input logic [255:0] vl,
                           input int exp_lat, input bit intr);
        int k;
        int lat;
        int base;
        push_miss(a, w, d, vt, vl);
        miss_valid_i = 1'b1;
        miss_addr_i = a;
        miss_is_write_i = w;
        victim_dirty_i = d;
        victim_tag_i = vt;
        victim_line_i = vl;
        k = 0;
        do begin
            cycle(1'b1);
            k++;
        end while (!(miss_busy_o && !fill_valid_o) && k < 10);
        n_cmp++;
        if (miss_busy_o !== 1'b1) begin
            n_fail++;
            $error("FAIL accept_busy: observed %0h expected 1", miss_busy_o);
        end
        miss_valid_i = 1'b0;
        miss_addr_i = $urandom;
        victim_dirty_i = ~d;
        victim_tag_i = ~vt;
        victim_line_i = ~vl;
        base = fills_seen;
        lat = 0;
        while (fills_seen == base && lat < 400) begin
            cycle(1'b1);
            lat++;
            if (intr && lat == 4) begin
                miss_valid_i = 1'b1;
                miss_addr_i = 32'hDEAD_BEE0;
                miss_is_write_i = ~w;
                victim_dirty_i = 1'b1;
            end
            if (intr && lat == 5) miss_valid_i = 1'b0;
        end
        n_cmp++;
        if (fills_seen !== base + 1) begin
            n_fail++;
            $error("FAIL fill_arrived: observed %0d expected %0d", fills_seen, base + 1);
        end
        if (exp_lat > 0) begin
            n_cmp++;
            if (lat + 1 !== exp_lat) begin
                n_fail++;
                $error("FAIL fill_latency: observed %0d expected %0d", lat + 1, exp_lat);
            end
        end
    endtask

    task automatic check_idle_zero();
        n_cmp++;
        if (miss_busy_o !== 1'b0) begin
            n_fail++;
            $error("FAIL z_busy: observed %0h", miss_busy_o);
        end
        n_cmp++;
        if (fill_valid_o !== 1'b0) begin
            n_fail++;
            $error("FAIL z_fill_valid: observed %0h", fill_valid_o);
        end
        n_cmp++;
        if (mem_req_o !== 1'b0) begin
            n_fail++;
            $error("FAIL z_req: observed %0h", mem_req_o);
        end
        n_cmp++;
        if (mem_we_o !== 1'b0) begin
            n_fail++;
            $error("FAIL z_we: observed %0h", mem_we_o);
        end
        n_cmp++;
        if (mem_addr_o !== 32'h0) begin
            n_fail++;
            $error("FAIL z_addr: observed %0h", mem_addr_o);
        end
        n_cmp++;
        if (mem_wdata_o !== 32'h0) begin
            n_fail++;
            $error("FAIL z_wdata: observed %0h", mem_wdata_o);
        end
        n_cmp++;
        if (fill_line_o !== 256'h0) begin
            n_fail++;
            $error("FAIL z_fill_line: observed %0h", fill_line_o);
        end
        n_cmp++;
        if (fill_state_o !== 2'b00) begin
            n_fail++;
            $error("FAIL z_fill_state: observed %0h", fill_state_o);
        end
        n_cmp++;
        if (fill_index_o !== 10'h0) begin
            n_fail++;
            $error("FAIL z_fill_index: observed %0h", fill_index_o);
        end
        n_cmp++;
        if (fill_tag_o !== 17'h0) begin
            n_fail++;
            $error("FAIL z_fill_tag: observed %0h", fill_tag_o);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] vl;
        int k;
        int base;
        rst = 1'b1;
        miss_valid_i = 1'b0;
        miss_is_write_i = 1'b0;
        miss_addr_i = '0;
        victim_dirty_i = 1'b0;
        victim_tag_i = '0;
        victim_line_i = '0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        repeat (3) cycle(1'b1);
        check_idle_zero();
        rst = 1'b0;
        cycle(1'b1);

        vl = {8{32'h5555_AAAA}};
        do_miss(32'h0000_1040, 1'b0, 1'b0, 17'h1_5555, vl, 9, 1'b0);
        n_cmp++;
        if (fill_index_o !== 10'h082) begin
            n_fail++;
            $error("FAIL t1_index: observed %0h", fill_index_o);
        end
        n_cmp++;
        if (fill_tag_o !== 17'h00000) begin
            n_fail++;
            $error("FAIL t1_tag: observed %0h", fill_tag_o);
        end
        n_cmp++;
        if (fill_state_o !== 2'b01) begin
            n_fail++;
            $error("FAIL t1_state: observed %0h", fill_state_o);
        end
        n_cmp++;
        if (fill_line_o[31:0] !== 32'h0000_1040) begin
            n_fail++;
            $error("FAIL t1_word0: observed %0h", fill_line_o[31:0]);
        end
        n_cmp++;
        if (fill_line_o[255:224] !== 32'h0000_105C) begin
            n_fail++;
            $error("FAIL t1_word7: observed %0h", fill_line_o[255:224]);
        end
        repeat (3) cycle(1'b1);

        for (int i = 0; i < 8; i++) vl[32*i +: 32] = 32'hA0 + 32'(i);
        do_miss(32'h0001_8020, 1'b1, 1'b1, 17'h00002, vl, 17, 1'b0);
        n_cmp++;
        if (fill_state_o !== 2'b11) begin
            n_fail++;
            $error("FAIL t2_state: observed %0h", fill_state_o);
        end
        n_cmp++;
        if (fill_index_o !== 10'h001) begin
            n_fail++;
            $error("FAIL t2_index: observed %0h", fill_index_o);
        end
        repeat (3) cycle(1'b1);

        stall_en = 1'b1;
        do_miss(32'h0000_1040, 1'b0, 1'b0, 17'h0_0001, vl, 0, 1'b0);
        for (int i = 0; i < 8; i++) vl[32*i +: 32] = $urandom;
        do_miss(32'h0003_47E4, 1'b1, 1'b1, 17'h1_F0F0, vl, 0, 1'b0);
        stall_en = 1'b0;
        repeat (3) cycle(1'b1);

        do_miss(32'h0000_5A60, 1'b0, 1'b0, 17'h0_0003, vl, 9, 1'b1);
        repeat (4) cycle(1'b1);
        n_cmp++;
        if (fills_seen !== fills_exp) begin
            n_fail++;
            $error("FAIL t4_fill_count: observed %0d expected %0d", fills_seen, fills_exp);
        end

        push_miss(32'h0000_3000, 1'b0, 1'b0, 17'h0, vl);
        miss_valid_i = 1'b1;
        miss_addr_i = 32'h0000_3000;
        miss_is_write_i = 1'b0;
        victim_dirty_i = 1'b0;
        k = 0;
        do begin
            cycle(1'b1);
            k++;
        end while (!miss_busy_o && k < 10);
        miss_valid_i = 1'b0;
        base = rd_acks;
        k = 0;
        while (rd_acks < base + 3 && k < 100) begin
            cycle(1'b1);
            k++;
        end
        n_cmp++;
        if (rd_acks !== base + 3) begin
            n_fail++;
            $error("FAIL t5_rd_acks: observed %0d expected %0d", rd_acks, base + 3);
        end
        base = fills_seen;
        rst = 1'b1;
        cycle(1'b0);
        check_idle_zero();
        rst = 1'b0;
        exp_beats.delete();
        exp_fills.delete();
        fills_exp--;
        held = 1'b0;
        repeat (2) cycle(1'b1);
        n_cmp++;
        if (fills_seen !== base) begin
            n_fail++;
            $error("FAIL t5_no_fill: observed %0d expected %0d", fills_seen, base);
        end
        do_miss(32'h0000_3000, 1'b0, 1'b0, 17'h0, vl, 9, 1'b0);
        repeat (3) cycle(1'b1);

        for (int i = 0; i < 8; i++) vl[32*i +: 32] = $urandom;
        do_miss(32'h0007_FFE0, 1'b1, 1'b1, 17'h0_1234, vl, 17, 1'b0);
        do_miss(32'h1234_5678, 1'b0, 1'b0, 17'h1_FFFF, vl, 9, 1'b0);
        n_cmp++;
        if (fill_tag_o !== 17'h0_2468) begin
            n_fail++;
            $error("FAIL t6_tag: observed %0h", fill_tag_o);
        end
        n_cmp++;
        if (fill_index_o !== 10'h2B3) begin
            n_fail++;
            $error("FAIL t6_index: observed %0h", fill_index_o);
        end

        repeat (4) cycle(1'b1);
        n_cmp++;
        if (fills_seen !== fills_exp) begin
            n_fail++;
            $error("FAIL total_fills: observed %0d expected %0d", fills_seen, fills_exp);
        end
        n_cmp++;
        if (spurious !== 0) begin
            n_fail++;
            $error("FAIL spurious: observed %0d", spurious);
        end
        n_cmp++;
        if (exp_beats.size() !== 0) begin
            n_fail++;
            $error("FAIL beats_left: observed %0d", exp_beats.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
